// File: rtl/vend_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vend_if                                                    |
// | Brief   : Customer/restock strobes and registered vending responses. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vend_if;
  logic       sel_valid;
  logic [2:0] sel_id;
  logic       coin_valid;
  logic [3:0] coin_value;
  logic       cancel;
  logic       restock_valid;
  logic [2:0] restock_id;
  logic [3:0] restock_amount;
  logic       restock_err;
  logic       busy;
  logic       sold_out;
  logic       coin_reject;
  logic       dispense;
  logic [2:0] dispense_id;
  logic       change_valid;
  logic [4:0] change_amount;

  modport master (
    output sel_valid, sel_id, coin_valid, coin_value, cancel,
           restock_valid, restock_id, restock_amount,
    input  restock_err, busy, sold_out, coin_reject, dispense, dispense_id,
           change_valid, change_amount
  );

  modport slave (
    input  sel_valid, sel_id, coin_valid, coin_value, cancel,
           restock_valid, restock_id, restock_amount,
    output restock_err, busy, sold_out, coin_reject, dispense, dispense_id,
           change_valid, change_amount
  );
endinterface
`default_nettype wire

// File: rtl/vend_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vend_controller                                            |
// | Brief   : Purchase FSM with 8-entry stock/price table and restock.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vend_controller #(
  parameter logic [31:0] PRICE_INIT     = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 1000
) (
  input  wire logic clk,
  input  wire logic rst_n,
  vend_if.slave     bus
);

  localparam int                   c_TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TIMER_W-1:0] c_TIMEOUT = c_TIMER_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COLLECT  = 3'd1,
    S_DISPENSE = 3'd2,
    S_CHANGE   = 3'd3,
    S_REFUND   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [3:0]           r_count [8];
  logic [3:0]           w_count_next [8];
  logic [3:0]           w_price [8];
  logic [7:0]           w_err_vec;
  logic [2:0]           r_id;
  logic [3:0]           r_price_sel;
  logic [4:0]           r_credit;
  logic [4:0]           w_credit_next;
  logic [c_TIMER_W-1:0] r_timer;
  logic [c_TIMER_W-1:0] w_timer_next;
  logic [c_TIMER_W-1:0] w_timer_inc;
  logic [5:0]           w_coin_sum;
  logic [4:0]           w_credit_coin;
  logic [4:0]           w_change_diff;

  logic       w_latch;
  logic       w_sold_out;
  logic       w_dispense;
  logic       w_change_valid;
  logic [4:0] w_change_amount;

  logic       r_restock_err;
  logic       r_busy;
  logic       r_sold_out;
  logic       r_coin_reject;
  logic       r_dispense;
  logic [2:0] r_dispense_id;
  logic       r_change_valid;
  logic [4:0] r_change_amount;

  // Dispense decrement and restock add are folded into one saturating sum.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_entry
      logic       w_dec;
      logic [3:0] w_add;
      logic [4:0] w_sum;
      assign w_price[gi] = PRICE_INIT[4*gi +: 4];
      assign w_dec = (r_state == S_DISPENSE) && (r_id == 3'(gi));
      assign w_add = (bus.restock_valid && (bus.restock_id == 3'(gi))) ?
                     bus.restock_amount : 4'd0;
      assign w_sum = {1'b0, r_count[gi]} - {4'b0, w_dec} + {1'b0, w_add};
      assign w_count_next[gi] = w_sum[4] ? 4'd15 : w_sum[3:0];
      assign w_err_vec[gi]    = w_sum[4];
    end
  endgenerate

  assign w_coin_sum    = {1'b0, r_credit} + {2'b0, bus.coin_value};
  assign w_credit_coin = w_coin_sum[5] ? 5'd31 : w_coin_sum[4:0];
  assign w_timer_inc   = r_timer + 1'b1;
  assign w_change_diff = r_credit - {1'b0, r_price_sel};

  always_comb begin
    w_state_next    = r_state;
    w_credit_next   = r_credit;
    w_timer_next    = r_timer;
    w_latch         = 1'b0;
    w_sold_out      = 1'b0;
    w_dispense      = 1'b0;
    w_change_valid  = 1'b0;
    w_change_amount = 5'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.sel_valid) begin
          if (r_count[bus.sel_id] == 4'd0) begin
            w_sold_out = 1'b1;
          end else begin
            w_state_next  = S_COLLECT;
            w_latch       = 1'b1;
            w_credit_next = 5'd0;
            w_timer_next  = '0;
          end
        end
      end
      S_COLLECT: begin
        if (bus.coin_valid) begin
          w_credit_next = w_credit_coin;
          w_timer_next  = '0;
        end else begin
          w_timer_next  = w_timer_inc;
        end
        // Cancel outranks a purchase; the dispense test uses pre-coin credit.
        if (bus.cancel) begin
          w_state_next    = S_REFUND;
          w_change_valid  = (w_credit_next != 5'd0);
          w_change_amount = w_credit_next;
        end else if (r_credit >= {1'b0, r_price_sel}) begin
          w_state_next = S_DISPENSE;
          w_dispense   = 1'b1;
        end else if (!bus.coin_valid && (w_timer_inc == c_TIMEOUT)) begin
          w_state_next    = S_REFUND;
          w_change_valid  = (r_credit != 5'd0);
          w_change_amount = r_credit;
        end
      end
      S_DISPENSE: begin
        w_state_next    = S_CHANGE;
        w_change_valid  = (w_change_diff != 5'd0);
        w_change_amount = w_change_diff;
      end
      S_CHANGE, S_REFUND: begin
        w_state_next  = S_IDLE;
        w_credit_next = 5'd0;
      end
      default: begin
        w_state_next  = S_IDLE;
        w_credit_next = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_id            <= 3'd0;
      r_price_sel     <= 4'd0;
      r_credit        <= 5'd0;
      r_timer         <= '0;
      r_restock_err   <= 1'b0;
      r_busy          <= 1'b0;
      r_sold_out      <= 1'b0;
      r_coin_reject   <= 1'b0;
      r_dispense      <= 1'b0;
      r_dispense_id   <= 3'd0;
      r_change_valid  <= 1'b0;
      r_change_amount <= 5'd0;
      for (int i = 0; i < 8; i++) r_count[i] <= 4'd0;
    end else begin
      r_state         <= w_state_next;
      r_credit        <= w_credit_next;
      r_timer         <= w_timer_next;
      r_restock_err   <= |w_err_vec;
      r_busy          <= (w_state_next != S_IDLE);
      r_sold_out      <= w_sold_out;
      r_coin_reject   <= bus.coin_valid && (r_state != S_COLLECT);
      r_dispense      <= w_dispense;
      r_dispense_id   <= w_dispense ? r_id : 3'd0;
      r_change_valid  <= w_change_valid;
      r_change_amount <= w_change_valid ? w_change_amount : 5'd0;
      for (int i = 0; i < 8; i++) r_count[i] <= w_count_next[i];
      if (w_latch) begin
        r_id        <= bus.sel_id;
        r_price_sel <= w_price[bus.sel_id];
      end
    end
  end

  assign bus.restock_err   = r_restock_err;
  assign bus.busy          = r_busy;
  assign bus.sold_out      = r_sold_out;
  assign bus.coin_reject   = r_coin_reject;
  assign bus.dispense      = r_dispense;
  assign bus.dispense_id   = r_dispense_id;
  assign bus.change_valid  = r_change_valid;
  assign bus.change_amount = r_change_amount;

endmodule
`default_nettype wire

// File: tb/tb_vend_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_vend_controller                                         |
// | Brief   : Directed scoreboard bench for vend_controller.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vend_controller;
  localparam int          TO    = 16;
  // price2=6, price3=0, price7=15, all others 0
  localparam logic [31:0] PRICE = 32'hF000_0600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [13:0] exp_q [$];
  string       tag_q [$];

  vend_if bus ();

  vend_controller #(.PRICE_INIT(PRICE), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {restock_err, busy, sold_out, coin_reject, dispense, dispense_id, change_valid, change_amount}
  function automatic logic [13:0] ev(input logic re, input logic bz, input logic so,
                                     input logic cr, input logic dp, input logic [2:0] did,
                                     input logic cv, input logic [4:0] ca);
    return {re, bz, so, cr, dp, did, cv, ca};
  endfunction

  function automatic logic [13:0] obs();
    return {bus.restock_err, bus.busy, bus.sold_out, bus.coin_reject, bus.dispense,
            bus.dispense_id, bus.change_valid, bus.change_amount};
  endfunction

  task automatic clear_inputs();
    bus.sel_valid      = 1'b0;
    bus.sel_id         = 3'd0;
    bus.coin_valid     = 1'b0;
    bus.coin_value     = 4'd0;
    bus.cancel         = 1'b0;
    bus.restock_valid  = 1'b0;
    bus.restock_id     = 3'd0;
    bus.restock_amount = 4'd0;
  endtask

  task automatic check_out();
    logic [13:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs() === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", t, obs(), e);
    end
  endtask

  task automatic cyc(input string tag, input logic [13:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
    clear_inputs();
  endtask

  task automatic sel(input logic [2:0] id);
    bus.sel_valid = 1'b1;
    bus.sel_id    = id;
  endtask

  task automatic coin(input logic [3:0] v);
    bus.coin_valid = 1'b1;
    bus.coin_value = v;
  endtask

  task automatic restock(input logic [2:0] id, input logic [3:0] amt);
    bus.restock_valid  = 1'b1;
    bus.restock_id     = id;
    bus.restock_amount = amt;
  endtask

  logic [13:0] Z, B;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1);
  end

  initial begin
    Z = ev(0, 0, 0, 0, 0, 3'd0, 0, 5'd0);
    B = ev(0, 1, 0, 0, 0, 3'd0, 0, 5'd0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(Z); tag_q.push_back("reset_outputs");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // basic purchase with change
    restock(3'd2, 4'd5);        cyc("t1_restock", Z);
    sel(3'd2);                  cyc("t1_sel", B);
    coin(4'd4);                 cyc("t1_coin_a", B);
    coin(4'd4);                 cyc("t1_coin_b", B);
                                cyc("t1_dispense", ev(0, 1, 0, 0, 1, 3'd2, 0, 5'd0));
                                cyc("t1_change", ev(0, 1, 0, 0, 0, 3'd0, 1, 5'd2));
                                cyc("t1_idle", Z);

    // sold out
    sel(3'd5);                  cyc("t2_sold_out", ev(0, 0, 1, 0, 0, 3'd0, 0, 5'd0));
                                cyc("t2_quiet", Z);

    // cancel with a coin in the same cycle
    sel(3'd2);                  cyc("t3_sel", B);
    coin(4'd3);                 cyc("t3_coin", B);
    coin(4'd2); bus.cancel = 1; cyc("t3_refund", ev(0, 1, 0, 0, 0, 3'd0, 1, 5'd5));
                                cyc("t3_idle", Z);

    // restock saturation and zero amount
    restock(3'd1, 4'd14);       cyc("t4_fill14", Z);
    restock(3'd1, 4'd3);        cyc("t4_sat", ev(1, 0, 0, 0, 0, 3'd0, 0, 5'd0));
    restock(3'd1, 4'd1);        cyc("t4_full", ev(1, 0, 0, 0, 0, 3'd0, 0, 5'd0));
    restock(3'd1, 4'd0);        cyc("t4_zero", Z);
    coin(4'd5);                 cyc("t4_coin_idle", ev(0, 0, 0, 1, 0, 3'd0, 0, 5'd0));

    // timeout refund
    sel(3'd2);                  cyc("t5_sel", B);
    coin(4'd1);                 cyc("t5_coin", B);
    for (int k = 1; k < TO; k++) cyc($sformatf("t5_wait%0d", k), B);
                                cyc("t5_timeout", ev(0, 1, 0, 0, 0, 3'd0, 1, 5'd1));
                                cyc("t5_idle", Z);

    // restock during dispense, coin during change
    sel(3'd2);                  cyc("t6_sel", B);
    coin(4'd4);                 cyc("t6_coin_a", B);
    coin(4'd4);                 cyc("t6_coin_b", B);
                                cyc("t6_dispense", ev(0, 1, 0, 0, 1, 3'd2, 0, 5'd0));
    restock(3'd2, 4'd2);        cyc("t6_change", ev(0, 1, 0, 0, 0, 3'd0, 1, 5'd2));
    coin(4'd7);                 cyc("t6_coin_reject", ev(0, 0, 0, 1, 0, 3'd0, 0, 5'd0));
    restock(3'd2, 4'd10);       cyc("t6_probe_fill", Z);
    restock(3'd2, 4'd1);        cyc("t6_probe_full", ev(1, 0, 0, 0, 0, 3'd0, 0, 5'd0));

    // zero price dispenses one cycle after selection, no change
    restock(3'd3, 4'd1);        cyc("t7_restock", Z);
    sel(3'd3);                  cyc("t7_sel", B);
                                cyc("t7_dispense", ev(0, 1, 0, 0, 1, 3'd3, 0, 5'd0));
                                cyc("t7_nochange", B);
                                cyc("t7_idle", Z);
    sel(3'd3);                  cyc("t7_empty", ev(0, 0, 1, 0, 0, 3'd0, 0, 5'd0));

    // credit saturates at 31
    restock(3'd7, 4'd1);        cyc("t8_restock", Z);
    sel(3'd7);                  cyc("t8_sel", B);
    coin(4'd14);                cyc("t8_coin_a", B);
    coin(4'd15);                cyc("t8_coin_b", B);
    coin(4'd15);                cyc("t8_dispense", ev(0, 1, 0, 0, 1, 3'd7, 0, 5'd0));
                                cyc("t8_change", ev(0, 1, 0, 0, 0, 3'd0, 1, 5'd16));
                                cyc("t8_idle", Z);

    // reset mid-purchase discards credit and stock
    sel(3'd2);                  cyc("t9_sel", B);
    coin(4'd4);                 cyc("t9_coin", B);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(Z); tag_q.push_back("t9_async_reset");
    check_out();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
                                cyc("t9_no_change", Z);
    sel(3'd2);                  cyc("t9_stock_cleared", ev(0, 0, 1, 0, 0, 3'd0, 0, 5'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
